// File: rtl/negedge_frame_tx_pkg.sv
// negedge_frame_tx_pkg
// Shared definitions for the falling-edge serial frame transmitter:
//   tx_state_e  - transmitter FSM states
//   IDLE_LEVEL  - level driven on the serial line between frames
//   frameLength - number of bit periods one frame occupies on the line
package negedge_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // One start bit, the payload, an optional parity bit and the stop bits.
  function automatic int frameLength(input int dataW, input int stopBits, input bit parityEn);
    return 1 + dataW + (parityEn ? 1 : 0) + stopBits;
  endfunction

endpackage

// File: rtl/negedge_frame_fifo.sv
// negedge_frame_fifo
// Small synchronous FIFO clocked on the falling edge of clkin_data with an
// asynchronous active-high reset. The head word is presented combinationally
// on popData_o whenever the FIFO is not empty.
//
// Ports:
//   clkin_data  - clock, all flops use its falling edge
//   reset       - asynchronous active-high reset, empties the FIFO
//   push_i      - write pushData_i (ignored while full)
//   pushData_i  - word to write
//   pop_i       - discard the head word (ignored while empty)
//   popData_o   - current head word
//   full_o      - occupancy equals DEPTH
//   empty_o     - occupancy is zero
//   count_o     - current occupancy, 0..DEPTH
module negedge_frame_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clkin_data,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign popData_o = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap simply by overflowing.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(negedge clkin_data or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: a slot is only ever read after it has been written.
  always_ff @(negedge clkin_data) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/negedge_frame_tx.sv
// negedge_frame_tx
// Serial frame transmitter launching on the falling edge of clkin_data.
// Words arrive over a valid/ready handshake into a small FIFO and are sent
// as idle-high frames: start bit (0), payload LSB first, optional even
// parity bit, then STOP_BITS stop bits (1). Back-to-back frames follow each
// other with no idle gap while the FIFO holds data.
//
// Optional feature macro: NEGEDGE_FRAME_TX_PARITY_EN
//   defined   - a parity bit (XOR of the payload) is sent after the payload
//   undefined - no parity bit; the payload is followed directly by the stop bits
//
// Ports:
//   clkin_data   - clock, all flops use its falling edge
//   reset        - asynchronous active-high reset, aborts any frame
//   in_valid     - a word is offered
//   in_data      - the offered word
//   in_ready     - FIFO can accept a word (not full)
//   tx_out       - serial line, idle high
//   tx_busy      - a frame is in progress
//   frame_count  - completed frames, wraps modulo 256
module negedge_frame_tx
  import negedge_frame_tx_pkg::*;
#(
  parameter int DATA_W     = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic              clkin_data,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic [7:0]        frame_count
);

  // A single-bit payload still needs a one-bit index register.
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bitIdx_q, bitIdx_d;
  logic              stopCnt_q, stopCnt_d;
  logic              txOut_q, txOut_d;
  logic [7:0]        frameCnt_q, frameCnt_d;
`ifdef NEGEDGE_FRAME_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic              fifoPush;
  logic              fifoPop;
  logic [DATA_W-1:0] fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  unusedFifoCount;

  // Ready depends only on registered occupancy, never on in_valid.
  assign in_ready    = !fifoFull;
  assign fifoPush    = in_valid && in_ready;
  assign tx_out      = txOut_q;
  assign tx_busy     = (state_q != IDLE);
  assign frame_count = frameCnt_q;

  negedge_frame_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clkin_data (clkin_data),
    .reset      (reset),
    .push_i     (fifoPush),
    .pushData_i (in_data),
    .pop_i      (fifoPop),
    .popData_o  (fifoHead),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (unusedFifoCount)
  );

  // tx_out is registered, so each state's next-state logic sets the level
  // that the following bit period will carry. START therefore already
  // launches payload bit 0, and DATA launches bits 1..DATA_W-1 while
  // bitIdx_q counts the payload bits already on the line.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitIdx_d   = bitIdx_q;
    stopCnt_d  = stopCnt_q;
    txOut_d    = txOut_q;
    frameCnt_d = frameCnt_q;
    fifoPop    = 1'b0;
`ifdef NEGEDGE_FRAME_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        txOut_d = IDLE_LEVEL;
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoHead;
`ifdef NEGEDGE_FRAME_TX_PARITY_EN
          parity_d = ^fifoHead;
`endif
          txOut_d = 1'b0;
          state_d = START;
        end
      end

      START: begin
        txOut_d  = shift_q[0];
        shift_d  = shift_q >> 1;
        bitIdx_d = '0;
        state_d  = DATA;
      end

      DATA: begin
        if (bitIdx_q == LAST_IDX) begin
`ifdef NEGEDGE_FRAME_TX_PARITY_EN
          txOut_d = parity_q;
          state_d = PAR;
`else
          txOut_d   = IDLE_LEVEL;
          stopCnt_d = 1'b0;
          state_d   = STOP;
`endif
        end else begin
          txOut_d  = shift_q[0];
          shift_d  = shift_q >> 1;
          bitIdx_d = bitIdx_q + IDX_W'(1);
        end
      end

`ifdef NEGEDGE_FRAME_TX_PARITY_EN
      PAR: begin
        txOut_d   = IDLE_LEVEL;
        stopCnt_d = 1'b0;
        state_d   = STOP;
      end
`endif

      STOP: begin
        if (stopCnt_q == STOP_LAST) begin
          // Frame complete; chain straight into the next one if a word waits.
          frameCnt_d = frameCnt_q + 8'd1;
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            shift_d = fifoHead;
`ifdef NEGEDGE_FRAME_TX_PARITY_EN
            parity_d = ^fifoHead;
`endif
            txOut_d = 1'b0;
            state_d = START;
          end else begin
            txOut_d = IDLE_LEVEL;
            state_d = IDLE;
          end
        end else begin
          txOut_d   = IDLE_LEVEL;
          stopCnt_d = stopCnt_q + 1'b1;
        end
      end

      default: begin
        txOut_d = IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(negedge clkin_data or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      stopCnt_q  <= 1'b0;
      txOut_q    <= IDLE_LEVEL;
      frameCnt_q <= 8'd0;
`ifdef NEGEDGE_FRAME_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitIdx_q   <= bitIdx_d;
      stopCnt_q  <= stopCnt_d;
      txOut_q    <= txOut_d;
      frameCnt_q <= frameCnt_d;
`ifdef NEGEDGE_FRAME_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
